// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing monitor: 640x480 @ 60 Hz geometry,
// error_code bit positions and the frame FSM encoding.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;

  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;

  localparam int ERR_H = 0;
  localparam int ERR_V = 1;
  localparam int ERR_A = 2;

  typedef enum logic {
    WAIT_VS = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/vga_line_meter.sv
// Per-line measurement: h_sync falling-edge detect plus saturating counters
// for line length, h_sync low width and display_area clocks.
module vga_line_meter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W   = 10,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int H_SYNC  = VGA_H_SYNC
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             h_sync_p0,
  input  logic             display_area_p0,
  output logic             line_end,
  output logic [CNT_W-1:0] line_total,
  output logic [CNT_W-1:0] sync_width,
  output logic [CNT_W-1:0] active_count,
  output logic             line_mismatch
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic             h_sync_p1;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] sync_cnt;
  logic [CNT_W-1:0] de_cnt;

  assign line_end      = h_sync_p1 & ~h_sync_p0;
  assign line_total    = clk_cnt;
  assign sync_width    = sync_cnt;
  assign active_count  = de_cnt;
  assign line_mismatch = (clk_cnt != H_TOTAL_C) || (sync_cnt != H_SYNC_C);

  // p0 -> p1: edge history and per-line counters; the edge cycle opens the new line
  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_sync_p1 <= 1'b0;
      clk_cnt   <= '0;
      sync_cnt  <= '0;
      de_cnt    <= '0;
    end else begin
      h_sync_p1 <= h_sync_p0;
      if (line_end) begin
        clk_cnt  <= CNT_ONE;
        sync_cnt <= CNT_ONE;
        de_cnt   <= display_area_p0 ? CNT_ONE : '0;
      end else begin
        clk_cnt <= sat_inc(clk_cnt);
        if (!h_sync_p0)
          sync_cnt <= sat_inc(sync_cnt);
        if (display_area_p0)
          de_cnt <= sat_inc(de_cnt);
      end
    end
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// VGA sink: measures frame geometry, pixel checksum, lock status and sticky
// timing errors from the h_sync/v_sync/display_area/pixel stream.
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int PIXEL_W     = 10,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               display_area,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic               clear_error,
  output logic [CNT_W-1:0]   h_total_meas,
  output logic [CNT_W-1:0]   h_sync_meas,
  output logic [CNT_W-1:0]   active_px_meas,
  output logic [CNT_W-1:0]   v_total_meas,
  output logic [CNT_W-1:0]   v_sync_meas,
  output logic [CNT_W-1:0]   active_ln_meas,
  output logic [15:0]        frame_sum,
  output logic               frame_done,
  output logic               locked,
  output logic               timing_error,
  output logic [2:0]         error_code
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
  localparam int               LCK_W      = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCK_W-1:0] LOCK_C     = LCK_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic               h_sync_p0, v_sync_p0, display_area_p0;
  logic [PIXEL_W-1:0] pixel_p0;
  logic               v_sync_p1;
  logic               vs_fall;
  logic [15:0]        px16;

  logic               line_end;
  logic [CNT_W-1:0]   line_total, sync_width, active_count;
  logic               line_mismatch;

  state_t             state_q, state_d;
  logic               frame_close;

  logic [CNT_W-1:0]   ln_cnt, vs_w, act_ln, last_htot, last_hsync, last_act;
  logic               hmis_acc, amis_acc;
  logic [15:0]        sum_acc;
  logic [LCK_W-1:0]   clean_cnt, clean_inc;

  logic               act_line, amis_line;
  logic               hmis_fin, vmis_fin, amis_fin, frame_bad;
  logic [CNT_W-1:0]   act_ln_fin;
  logic [2:0]         err_new, err_d;

  assign vs_fall = v_sync_p1 & ~v_sync_p0;
  assign px16    = 16'(pixel_p0);

  // input -> p0: single register stage on every sampled input
  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_sync_p0       <= 1'b0;
      v_sync_p0       <= 1'b0;
      display_area_p0 <= 1'b0;
      pixel_p0        <= '0;
      v_sync_p1       <= 1'b0;
    end else begin
      h_sync_p0       <= h_sync;
      v_sync_p0       <= v_sync;
      display_area_p0 <= display_area;
      pixel_p0        <= pixel;
      v_sync_p1       <= v_sync_p0;
    end
  end

  vga_line_meter #(
    .CNT_W  (CNT_W),
    .H_TOTAL(H_TOTAL),
    .H_SYNC (H_SYNC)
  ) u_line_meter (
    .clock_25       (clock_25),
    .reset          (reset),
    .h_sync_p0      (h_sync_p0),
    .display_area_p0(display_area_p0),
    .line_end       (line_end),
    .line_total     (line_total),
    .sync_width     (sync_width),
    .active_count   (active_count),
    .line_mismatch  (line_mismatch)
  );

  always_ff @(posedge clock_25) begin
    if (reset) state_q <= WAIT_VS;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_close = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_fall) state_d = MEASURE;
      MEASURE: frame_close = vs_fall;
      default: state_d = WAIT_VS;
    endcase
  end

  // Closing values fold in the line that ends on the closing cycle; a
  // coincident h_sync edge still counts as line 0 of the new frame.
  always_comb begin
    act_line   = line_end && (active_count != '0);
    amis_line  = act_line && (active_count != H_ACTIVE_C);
    act_ln_fin = act_line ? sat_inc(act_ln) : act_ln;
    hmis_fin   = hmis_acc | (line_end & line_mismatch);
    vmis_fin   = (ln_cnt != V_TOTAL_C) || (vs_w != V_SYNC_C);
    amis_fin   = amis_acc | amis_line | (act_ln_fin != V_ACTIVE_C);
    err_new        = '0;
    err_new[ERR_H] = hmis_fin;
    err_new[ERR_V] = vmis_fin;
    err_new[ERR_A] = amis_fin;
    frame_bad      = |err_new;
    err_d = clear_error ? 3'b000 : error_code;
    if (frame_close)
      err_d = err_d | err_new;
    clean_inc = (clean_cnt >= LOCK_C) ? clean_cnt : clean_cnt + LCK_W'(1);
  end

  // p0 -> frame accumulators: restart on every v_sync edge, including the first
  always_ff @(posedge clock_25) begin
    if (reset) begin
      ln_cnt     <= '0;
      vs_w       <= '0;
      act_ln     <= '0;
      last_htot  <= '0;
      last_hsync <= '0;
      last_act   <= '0;
      hmis_acc   <= 1'b0;
      amis_acc   <= 1'b0;
      sum_acc    <= '0;
    end else if (vs_fall) begin
      ln_cnt     <= line_end ? CNT_ONE : '0;
      vs_w       <= line_end ? CNT_ONE : '0;
      act_ln     <= '0;
      last_htot  <= '0;
      last_hsync <= '0;
      last_act   <= '0;
      hmis_acc   <= 1'b0;
      amis_acc   <= 1'b0;
      sum_acc    <= display_area_p0 ? px16 : 16'd0;
    end else begin
      if (line_end) begin
        ln_cnt     <= sat_inc(ln_cnt);
        last_htot  <= line_total;
        last_hsync <= sync_width;
        if (!v_sync_p0)
          vs_w <= sat_inc(vs_w);
      end
      if (act_line) begin
        act_ln   <= sat_inc(act_ln);
        last_act <= active_count;
      end
      hmis_acc <= hmis_fin;
      amis_acc <= amis_acc | amis_line;
      if (display_area_p0)
        sum_acc <= sum_acc + px16;
    end
  end

  // frame close -> reported measurements, lock and sticky error state
  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_total_meas   <= '0;
      h_sync_meas    <= '0;
      active_px_meas <= '0;
      v_total_meas   <= '0;
      v_sync_meas    <= '0;
      active_ln_meas <= '0;
      frame_sum      <= '0;
      frame_done     <= 1'b0;
      locked         <= 1'b0;
      clean_cnt      <= '0;
      error_code     <= '0;
      timing_error   <= 1'b0;
    end else begin
      frame_done   <= frame_close;
      error_code   <= err_d;
      timing_error <= |err_d;
      if (frame_close) begin
        h_total_meas   <= line_end ? line_total : last_htot;
        h_sync_meas    <= line_end ? sync_width : last_hsync;
        active_px_meas <= act_line ? active_count : last_act;
        v_total_meas   <= ln_cnt;
        v_sync_meas    <= vs_w;
        active_ln_meas <= act_ln_fin;
        frame_sum      <= sum_acc;
        clean_cnt      <= frame_bad ? '0 : clean_inc;
        locked         <= !frame_bad && (clean_inc == LOCK_C);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down 20x15 raster
// (sync 3/2, active 12x10) so complete frames stay short.
module tb_vga_timing_monitor;

  localparam int TH  = 20;
  localparam int HS  = 3;
  localparam int HA0 = 5;
  localparam int HA1 = 17;
  localparam int TV  = 15;
  localparam int VS  = 2;
  localparam int VA0 = 3;
  localparam int VA1 = 13;

  logic       clock_25 = 1'b0;
  logic       reset = 1'b1;
  logic       h_sync = 1'b1;
  logic       v_sync = 1'b1;
  logic       display_area = 1'b0;
  logic [9:0] pixel = '0;
  logic       clear_error = 1'b0;
  logic [9:0] h_total_meas, h_sync_meas, active_px_meas;
  logic [9:0] v_total_meas, v_sync_meas, active_ln_meas;
  logic [15:0] frame_sum;
  logic       frame_done, locked, timing_error;
  logic [2:0] error_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [9:0]  s_htot, s_hsync, s_apx, s_vtot, s_vsync, s_aln;
  logic [15:0] s_sum;
  logic        s_lock, s_terr;
  logic [2:0]  s_ecode;

  vga_timing_monitor #(
    .CNT_W(10), .PIXEL_W(10),
    .H_TOTAL(TH), .H_SYNC(HS), .H_ACTIVE(HA1 - HA0),
    .V_TOTAL(TV), .V_SYNC(VS), .V_ACTIVE(VA1 - VA0),
    .LOCK_FRAMES(2)
  ) dut (
    .clock_25(clock_25), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .display_area(display_area), .pixel(pixel), .clear_error(clear_error),
    .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas),
    .active_px_meas(active_px_meas), .v_total_meas(v_total_meas),
    .v_sync_meas(v_sync_meas), .active_ln_meas(active_ln_meas),
    .frame_sum(frame_sum), .frame_done(frame_done), .locked(locked),
    .timing_error(timing_error), .error_code(error_code)
  );

  always #5 clock_25 = ~clock_25;

  always @(negedge clock_25) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      s_htot = h_total_meas;  s_hsync = h_sync_meas;  s_apx = active_px_meas;
      s_vtot = v_total_meas;  s_vsync = v_sync_meas;  s_aln = active_ln_meas;
      s_sum  = frame_sum;     s_lock  = locked;       s_terr = timing_error;
      s_ecode = error_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int n_lines, input int bad_line, input logic [9:0] pix,
                            input bit vs_en, input int clr_line, input int clr_hc);
    for (int vc = 0; vc < n_lines; vc++) begin
      for (int hc = 0; hc < TH + ((vc == bad_line) ? 1 : 0); hc++) begin
        @(negedge clock_25);
        h_sync       = !(hc < HS);
        v_sync       = !(vs_en && vc < VS);
        display_area = (hc >= HA0 && hc < HA1 && vc >= VA0 && vc < VA1);
        pixel        = display_area ? pix : 10'd0;
        clear_error  = (vc == clr_line && hc == clr_hc);
      end
    end
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock_25);
      h_sync = 1'b1; display_area = 1'b0; pixel = '0;
      v_sync = (i >= 5) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic chk_nominal(input string tag, input logic [15:0] sum);
    chk({tag, "_htot"}, s_htot, 20);
    chk({tag, "_hsync"}, s_hsync, 3);
    chk({tag, "_apx"}, s_apx, 12);
    chk({tag, "_vtot"}, s_vtot, 15);
    chk({tag, "_vsync"}, s_vsync, 2);
    chk({tag, "_aln"}, s_aln, 10);
    chk({tag, "_sum"}, s_sum, sum);
  endtask

  initial begin
    repeat (3) @(negedge clock_25);
    chk("rst_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_htot", h_total_meas, 0);
    chk("rst_ecode", error_code, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock_25);

    send_frame(TV, -1, 10'd3, 1'b1, -1, 0);
    chk("f0_no_done", done_cnt, 0);
    send_frame(TV, -1, 10'd1000, 1'b1, -1, 0);
    chk("f0_done", done_cnt, 1);
    chk_nominal("f0", 16'd360);
    chk("f0_lock", s_lock, 0);
    chk("f0_terr", s_terr, 0);
    send_frame(TV, 5, 10'd5, 1'b1, -1, 0);
    chk("f1_done", done_cnt, 2);
    chk_nominal("f1", 16'd54464);
    chk("f1_lock", s_lock, 1);
    send_frame(TV, -1, 10'd7, 1'b1, -1, 0);
    chk("f2_done", done_cnt, 3);
    chk("f2_ecode", s_ecode, 3'b001);
    chk("f2_terr", s_terr, 1);
    chk("f2_lock", s_lock, 0);
    chk("f2_htot", s_htot, 20);
    chk("f2_sum", s_sum, 16'd600);
    send_frame(TV, -1, 10'd3, 1'b1, -1, 0);
    chk("f3_lock", s_lock, 0);
    chk("f3_ecode", s_ecode, 3'b001);
    chk("f3_sum", s_sum, 16'd840);
    send_frame(TV, -1, 10'd3, 1'b1, 3, 5);
    chk("f4_done", done_cnt, 5);
    chk("f4_lock", s_lock, 1);
    chk("f4_ecode", s_ecode, 3'b001);
    chk("clr_ecode", error_code, 0);
    chk("clr_terr", timing_error, 0);

    send_frame(7, -1, 10'd3, 1'b1, -1, 0);
    chk("f5_done", done_cnt, 6);
    chk("f5_lock", s_lock, 1);
    chk("f5_ecode", s_ecode, 0);
    @(negedge clock_25);
    reset = 1'b1;
    @(negedge clock_25);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_htot", h_total_meas, 0);
    chk("mid_rst_vtot", v_total_meas, 0);
    chk("mid_rst_sum", frame_sum, 0);
    chk("mid_rst_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock_25);
    send_frame(TV, -1, 10'd3, 1'b1, -1, 0);
    chk("f7_no_done", done_cnt, 6);
    send_frame(TV, -1, 10'd9, 1'b1, -1, 0);
    chk("f7_done", done_cnt, 7);
    chk_nominal("f7", 16'd360);
    chk("f7_lock", s_lock, 0);
    chk("f7_ecode", s_ecode, 0);

    for (int f = 0; f < 70; f++)
      send_frame(TV, -1, 10'd1, 1'b0, -1, 0);
    chk("novs_no_done", done_cnt, 7);
    send_frame(TV, -1, 10'd3, 1'b1, -1, 0);
    chk("novs_done", done_cnt, 8);
    chk("novs_vtot", s_vtot, 1023);
    chk("novs_vsync", s_vsync, 2);
    chk("novs_ecode", s_ecode, 3'b110);
    chk("novs_lock", s_lock, 0);

    send_frame(TV, 5, 10'd3, 1'b1, -1, 0);
    chk("f79_done", done_cnt, 9);
    chk("f79_ecode", s_ecode, 3'b110);
    send_frame(1, -1, 10'd3, 1'b1, 0, 1);
    chk("coinc_done", done_cnt, 10);
    chk("coinc_ecode", s_ecode, 3'b001);
    chk("coinc_terr", s_terr, 1);
    chk("coinc_lock", s_lock, 0);

    vs_pulse();
    vs_pulse();
    repeat (3) @(negedge clock_25);
    chk("zero_done", done_cnt, 12);
    chk("zero_vtot", s_vtot, 0);
    chk("zero_htot", s_htot, 0);
    chk("zero_ecode", s_ecode, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
